// File: rtl/equiv_resp_checker_pkg.sv
// Shared definitions for the equivalence sweep stimulus and response sides.
package equiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int N_IN_DEF  = 3;
  localparam int N_OUT_DEF = 1;

  // Number of vectors in an exhaustive sweep of an n-bit input.
  function automatic int unsigned sweep_len(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/equiv_resp_checker_if.sv
// Sample channel carrying an applied vector and both implementations' outputs.
interface equiv_resp_checker_if #(
  parameter int N_IN  = equiv_pkg::N_IN_DEF,
  parameter int N_OUT = equiv_pkg::N_OUT_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic [N_OUT-1:0] out_a;
  logic [N_OUT-1:0] out_b;

  modport master (output in_valid, in_vec, out_a, out_b, input in_ready);
  modport slave  (input in_valid, in_vec, out_a, out_b, output in_ready);
endinterface

// File: rtl/equiv_resp_checker.sv
// Compares A/B outputs over an exhaustive input sweep, counting mismatches,
// capturing the first failing vector and flagging out-of-order samples.
module equiv_resp_checker
  import equiv_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  equiv_resp_checker_if.slave  smp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_count,
  output logic                 first_fail_valid,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 seq_err
);

  localparam logic [N_IN:0] LAST = (N_IN+1)'(sweep_len(N_IN) - 1);
  localparam logic [N_IN:0] ONE  = {{N_IN{1'b0}}, 1'b1};

  state_t           state_q;
  logic [N_IN:0]    exp_q;
  logic [N_IN:0]    cnt_q;
  logic             ffv_q;
  logic [N_IN-1:0]  ffvec_q;
  logic             seq_q;

  logic [N_OUT-1:0] diff_bits;
  logic             diff;
  logic             accept;

  assign diff_bits = smp.out_a ^ smp.out_b;
  assign diff      = |diff_bits;
  assign accept    = smp.in_valid && (state_q == RUN);

  // Termination keys off the expected index so a sweep is always 2^N_IN accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      cnt_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      seq_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            exp_q   <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            seq_q   <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (diff) begin
              cnt_q <= cnt_q + ONE;
              if (!ffv_q) begin
                ffv_q   <= 1'b1;
                ffvec_q <= smp.in_vec;
              end
            end
            if ({1'b0, smp.in_vec} != exp_q) seq_q <= 1'b1;
            exp_q <= exp_q + ONE;
            if (exp_q == LAST) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign smp.in_ready     = (state_q == RUN);
  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign pass             = done && (cnt_q == '0) && !seq_q;
  assign mismatch_count   = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign seq_err          = seq_q;

endmodule

// File: tb/tb_equiv_resp_checker.sv
// Directed and randomized sweeps of equiv_resp_checker against a reference model.
module tb_equiv_resp_checker;
  import equiv_pkg::*;

  localparam int NI = 3;
  localparam int NO = 1;
  localparam int NS = int'(sweep_len(NI));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, first_fail_valid, seq_err;
  logic [NI:0]   mismatch_count;
  logic [NI-1:0] first_fail_vec;

  equiv_resp_checker_if #(.N_IN(NI), .N_OUT(NO)) smp ();

  equiv_resp_checker #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .smp              (smp.slave),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_count   (mismatch_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .seq_err          (seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Two implementations of the same function: A = ~(a&b)&(a&b|a&c), B = a&~b&c.
  function automatic logic fa(input logic [2:0] v);
    return ~(v[2] & v[1]) & ((v[2] & v[1]) | (v[2] & v[0]));
  endfunction

  function automatic logic fb(input logic [2:0] v);
    return v[2] & ~v[1] & v[0];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, smp.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_count"}, mismatch_count, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
    chk({tag, "_ffvec"}, first_fail_vec, 0);
    chk({tag, "_seq"}, seq_err, 0);
  endtask

  // Entered and left at posedge+1; waits (bounded) for in_ready before the accept edge.
  task automatic send(input logic [2:0] v, input logic inv, input int gap, input string tag);
    int w;
    smp.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    smp.in_vec   = v;
    smp.out_a    = fa(v);
    smp.out_b    = fb(v) ^ inv;
    smp.in_valid = 1'b1;
    w = 0;
    while (w < 20) begin
      @(negedge clk);
      if (smp.in_ready) break;
      w++;
    end
    chk({tag, "_ready_wait"}, (w < 20), 1);
    @(posedge clk);
    #1;
    smp.in_valid = 1'b0;
  endtask

  task automatic run_sweep(input logic [2:0] vecs[8], input logic inv[8], input int maxgap,
                           input bit do_start, input bit with_valid, input bit hold_start,
                           input string tag);
    int          ecnt;
    bit          effv, eseq;
    logic [2:0]  effvec;
    ecnt = 0; effv = 0; eseq = 0; effvec = '0;
    for (int i = 0; i < NS; i++) begin
      if (fa(vecs[i]) != (fb(vecs[i]) ^ inv[i])) begin
        ecnt++;
        if (!effv) begin
          effv = 1;
          effvec = vecs[i];
        end
      end
      if (int'(vecs[i]) != i) eseq = 1;
    end
    if (do_start) begin
      start = 1'b1;
      if (with_valid) begin
        smp.in_vec   = 3'd0;
        smp.out_a    = 1'b1;
        smp.out_b    = 1'b0;
        smp.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      start = hold_start;
      smp.in_valid = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      if (i == NS - 1) start = 1'b0;
      send(vecs[i], inv[i], int'($urandom_range(maxgap, 0)), tag);
      if (i == NS - 2) begin
        chk({tag, "_pre_done"}, done, 0);
        chk({tag, "_pre_busy"}, busy, 1);
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, smp.in_ready, 0);
    chk({tag, "_pass"}, pass, (ecnt == 0 && !eseq));
    chk({tag, "_count"}, mismatch_count, ecnt);
    chk({tag, "_ffv"}, first_fail_valid, effv);
    if (effv) chk({tag, "_ffvec"}, first_fail_vec, effvec);
    chk({tag, "_seq"}, seq_err, eseq);
  endtask

  initial begin
    logic [2:0] vecs[8];
    logic       inv[8];
    logic [NI:0] held_cnt;
    logic [NI-1:0] held_vec;

    smp.in_valid = 1'b0;
    smp.in_vec   = '0;
    smp.out_a    = '0;
    smp.out_b    = '0;
    for (int i = 0; i < NS; i++) begin
      vecs[i] = 3'(i);
      inv[i]  = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean in-order sweep; start coincides with in_valid which must not be accepted.
    run_sweep(vecs, inv, 0, 1, 1, 0, "clean");

    inv[5] = 1'b1;
    run_sweep(vecs, inv, 0, 1, 0, 0, "mis5");
    inv[5] = 1'b0;

    inv[2] = 1'b1;
    inv[6] = 1'b1;
    run_sweep(vecs, inv, 3, 1, 0, 0, "mis26");
    inv[2] = 1'b0;
    inv[6] = 1'b0;

    vecs[2] = 3'd3;
    vecs[3] = 3'd2;
    run_sweep(vecs, inv, 1, 1, 0, 0, "order");
    vecs[2] = 3'd2;
    vecs[3] = 3'd3;

    // Mid-sweep reset discards partial results.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send(3'(i), (i == 1), 0, "partial");
    @(negedge clk);
    chk("partial_count", mismatch_count, 1);
    chk("partial_ffv", first_fail_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("post_reset_idle");
    run_sweep(vecs, inv, 2, 1, 0, 0, "after_reset");

    // start held through RUN, then stray in_valid in DONE.
    for (int i = 0; i < NS; i++) inv[i] = 1'($urandom_range(1, 0));
    run_sweep(vecs, inv, 1, 1, 0, 1, "hold_start");
    held_cnt = mismatch_count;
    held_vec = first_fail_vec;
    @(posedge clk);
    #1;
    smp.in_vec   = 3'd7;
    smp.out_a    = 1'b1;
    smp.out_b    = 1'b0;
    smp.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    smp.in_valid = 1'b0;
    chk("done_idle_count", mismatch_count, held_cnt);
    chk("done_idle_ffvec", first_fail_vec, held_vec);
    chk("done_idle_done", done, 1);
    chk("done_idle_ready", smp.in_ready, 0);

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rearm_busy", busy, 1);
    chk("rearm_done", done, 0);
    chk("rearm_count", mismatch_count, 0);
    chk("rearm_ffv", first_fail_valid, 0);
    chk("rearm_seq", seq_err, 0);
    for (int i = 0; i < NS; i++) inv[i] = 1'($urandom_range(1, 0));
    run_sweep(vecs, inv, 2, 0, 0, 0, "rearm");

    // Randomized sweeps: random mismatch masks and occasionally scrambled vectors.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) begin
        inv[i]  = ($urandom_range(3, 0) == 0);
        vecs[i] = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'(i);
      end
      run_sweep(vecs, inv, 3, 1, 0, 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
